// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - product-in / group-result-out handshake bundle for mac_accumulator
interface mac_accumulator_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 72,
    parameter int CNT_WIDTH = 16
);
    logic                 prod_valid;
    logic                 prod_ready;
    logic [2*WIDTH-1:0]   prod_data;
    logic                 prod_last;
    logic                 acc_valid;
    logic                 acc_ready;
    logic [ACC_WIDTH-1:0] acc_data;
    logic [CNT_WIDTH-1:0] acc_count;
    logic                 acc_ovf;

    modport master (
        output prod_valid, prod_data, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_count, acc_ovf
    );

    modport slave (
        input  prod_valid, prod_data, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_count, acc_ovf
    );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums unsigned products per last-delimited group and holds the result
// Optional MAC_ACC_SATURATE_EN: clamp the group sum at all-ones instead of wrapping.
module mac_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 72,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mac_accumulator_if.slave bus
);
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept;
    logic                 release_hs;

    assign bus.prod_ready = (state_q == ST_ACCUM);
    assign bus.acc_valid  = (state_q == ST_HOLD);
    assign bus.acc_data   = acc_q;
    assign bus.acc_count  = count_q;
    assign bus.acc_ovf    = ovf_q;

    assign accept     = bus.prod_valid && (state_q == ST_ACCUM);
    assign release_hs = bus.acc_ready && (state_q == ST_HOLD);

    // One extra bit above the accumulator captures the carry-out of this beat.
    assign sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, bus.prod_data};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (accept) begin
`ifdef MAC_ACC_SATURATE_EN
            acc_d = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
            acc_d = sum[ACC_WIDTH-1:0];
`endif
            if (count_q != {CNT_WIDTH{1'b1}}) begin
                count_d = count_q + CNT_ONE;
            end
            ovf_d = ovf_q | sum[ACC_WIDTH];
            if (bus.prod_last) begin
                state_d = ST_HOLD;
            end
        end else if (release_hs) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulation stage placed directly downstream of the combinational Booth `Multiplier`. It consumes unsigned `2*WIDTH`-bit products over a valid/ready handshake and sums them into a wide accumulator. Each group of products is closed by a `last` marker, and the block then presents the group's total, term count and overflow flag on an output valid/ready handshake. Together with `Multiplier` it forms a dot-product / MAC datapath.

## Interface
- `WIDTH`, 32, multiplier operand width; product width is `2*WIDTH`.
- `ACC_WIDTH`, 72, accumulator width; must be `>= 2*WIDTH`.
- `CNT_WIDTH`, 16, width of the term counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `prod_valid` in 1: product beat valid.
- `prod_ready` out 1: block accepts a beat.
- `prod_data` in `2*WIDTH`: unsigned product from `Multiplier.result`.
- `prod_last` in 1: beat is the final term of its group.
- `acc_valid` out 1: group result valid.
- `acc_ready` in 1: consumer accepts the result.
- `acc_data` out `ACC_WIDTH`: group sum.
- `acc_count` out `CNT_WIDTH`: number of beats in the group.
- `acc_ovf` out 1: sticky flag; the group sum exceeded `2^ACC_WIDTH-1`.

## Operation
- **States:** two.
  - ACCUM: `prod_ready=1`, `acc_valid=0`.
  - HOLD: `prod_ready=0`, `acc_valid=1`.
- **Accept:** a beat is accepted when `prod_valid && prod_ready`. On acceptance:
  - `acc <= acc + zero_extend(prod_data)`.
  - `count <= count + 1`, saturating at all-ones.
  - `ovf <= ovf | carry_out`.
- **Accept with `prod_last=1`:** the same update happens, then ACCUM→HOLD.
- **Release:** `acc_valid && acc_ready` in HOLD moves HOLD→ACCUM. At the same edge, `acc`, `count` and `ovf` clear to 0.
- **While ACCUM:**
  - `acc_data`, `acc_count` and `acc_ovf` show the running values.
  - These values are informational only; they are not qualified by `acc_valid`.
- **While HOLD:** `acc_data`, `acc_count` and `acc_ovf` are frozen until the release handshake.
- **Empty group:** impossible. A group needs at least one beat, so `acc_count >= 1` whenever `acc_valid=1`.
- **Arithmetic:**
  - Products are unsigned; no sign extension.
  - The adder is `ACC_WIDTH+1` bits wide; bit `ACC_WIDTH` is the carry.
  - Overflow handling depends on the macro; see Configuration.
- **Reset, including mid-group or in HOLD:**
  - State goes to ACCUM.
  - `acc`, `count` and `ovf` go to 0.
  - A pending result is discarded.
- **Reset values of outputs:** `prod_ready=1`, `acc_valid=0`, `acc_data=0`, `acc_count=0`, `acc_ovf=0`.
- **Beats during reset:** no beat is accepted while `rst_n=0`.

## Timing
- `prod_ready` is a combinational decode of the state register only. It has no path from `prod_valid` or `acc_ready`.
- **Throughput:** one product per cycle within a group.
- **Latency:** the beat with `prod_last` accepted at edge N gives `acc_valid=1` from cycle N+1. The sum shown includes that beat.
- **Group gap:** at least one cycle between groups.
  - `prod_ready=0` in every HOLD cycle, including the cycle of the release handshake.
  - The next group's first beat can be accepted at the edge after release.
- **Back-pressure:** `acc_valid` stays high until `acc_ready`. Outputs must not change while `acc_valid && !acc_ready`.
- **Deassert timing:** `acc_valid` drops the cycle after the release edge.
- **Inputs ignored in HOLD:** `prod_valid` and `prod_last` have no effect.

## Configuration
- Macro `MAC_ACC_SATURATE_EN`.
- **Defined:** on carry-out, `acc` clamps to all-ones (`2^ACC_WIDTH-1`) and remains there for the rest of the group. `ovf` is set.
- **Undefined:** `acc` wraps modulo `2^ACC_WIDTH`. `ovf` is still set sticky.
- Counter saturation and the handshake are identical in both builds.

## Test plan
- **Basic group:** `WIDTH=8`, `ACC_WIDTH=17`. Reset, then send beats 6, 20, 100 (last on 100), `acc_ready=1`.
  - `acc_valid` the cycle after 100 is accepted.
  - `acc_data=126`, `acc_count=3`, `acc_ovf=0`.
  - `prod_ready=0` for exactly one cycle.
- **Single beat, back-pressure:** beat 65025 with `last=1`, `acc_ready=0` for 5 cycles.
  - `acc_valid` and `acc_data=65025` are held stable.
  - `prod_ready=0` throughout.
  - Releases one cycle after `acc_ready` rises.
- **Overflow:** beats 65025, 65025, 65025 (last).
  - Without the macro: `acc_data=64003` (195075 mod 131072), `acc_ovf=1`.
  - With `MAC_ACC_SATURATE_EN`: `acc_data=131071`, `acc_ovf=1`.
- **Back-to-back groups:** stream {1, 2 last}, {3 last} with `prod_valid` held high.
  - Results are 3 (count 2), then 3 (count 1).
  - Beat 3 is accepted no earlier than the cycle after the first release.
  - The second group starts cleared.
- **Reset mid-group:** accept 50 and 60, pulse `rst_n` low asynchronously between edges.
  - All outputs read reset values immediately.
  - A following group {7 last} gives `acc_data=7`, `acc_count=1`.
- **Counter saturation:** `CNT_WIDTH=2`, six beats of 1 with the last flagged.
  - `acc_count=3`, `acc_data=6`.
